alu_exec_pipe: RTL and testbench

Two-stage execute pipeline that sits directly upstream of the 16-bit ALU (`alu_16bit`). It accepts register-addressed instructions over a valid/ready handshake and reads operands from an internal 8x16 register file. It drives registered, stable operands and opcode into the combinational ALU, then captures the ALU result and zero flag, writes the result back, and presents it downstream. Back-to-back dependent instructions are resolved by bypassing the ALU output.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_exec_pipe_regfile.sv | 45 ++++
 rtl/alu_exec_pipe.sv | 144 ++++++++++++++
 tb/tb_alu_exec_pipe.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, datapath width and register index type.
package alu_pkg;

  localparam int W      = 16;
  localparam int RIDX_W = 3;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_SHL   = 3'b010,
    OP_SHR   = 3'b011,
    OP_SRA   = 3'b100,
    OP_NAND  = 3'b101,
    OP_OR    = 3'b110,
    OP_SHADD = 3'b111
  } alu_op_e;

  typedef logic [RIDX_W-1:0] ridx_t;

endpackage

// File: rtl/alu_exec_pipe_regfile.sv
// 8x16 register file: two combinational read ports, two synchronous write ports
// (pipeline over external), r0 hardwired to zero.
module regfile_8x16
  import alu_pkg::*;
#(
  parameter int REGS = 8,
  parameter int W    = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  ridx_t        ra1,
  input  ridx_t        ra2,
  output logic [W-1:0] rd1,
  output logic [W-1:0] rd2,
  input  logic         pw_en,
  input  ridx_t        pw_addr,
  input  logic [W-1:0] pw_data,
  input  logic         xw_en,
  input  ridx_t        xw_addr,
  input  logic [W-1:0] xw_data
);

  logic [W-1:0] mem_q [REGS];
  logic [W-1:0] mem_d [REGS];

  // External write first so a pipeline write to the same index overrides it.
  always_comb begin
    mem_d = mem_q;
    if (xw_en) mem_d[xw_addr] = xw_data;
    if (pw_en) mem_d[pw_addr] = pw_data;
    mem_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd1 = mem_q[ra1];
  assign rd2 = mem_q[ra2];

endmodule

// File: rtl/alu_exec_pipe.sv
// Two-stage execute pipeline feeding an external combinational 16-bit ALU:
// E holds stable ALU operands, W captures the result and writes it back.
module alu_exec_pipe
  import alu_pkg::*;
#(
  parameter int REGS = 8,
  parameter int W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [RIDX_W-1:0] in_rd,
  input  logic [RIDX_W-1:0] in_rs1,
  input  logic [RIDX_W-1:0] in_rs2,
  input  logic              ld_en,
  input  logic [RIDX_W-1:0] ld_addr,
  input  logic [W-1:0]      ld_data,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  output logic [2:0]        alu_op,
  input  logic [W-1:0]      alu_out,
  input  logic              alu_zerof,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [W-1:0]      res_data,
  output logic [RIDX_W-1:0] res_rd,
  output logic              res_zero
);

  logic         e_valid_q, e_valid_d;
  logic [W-1:0] alu_a_q, alu_a_d;
  logic [W-1:0] alu_b_q, alu_b_d;
  alu_op_e      alu_op_q, alu_op_d;
  ridx_t        e_rd_q, e_rd_d;

  logic         res_valid_q, res_valid_d;
  logic [W-1:0] res_data_q, res_data_d;
  ridx_t        res_rd_q, res_rd_d;
  logic         res_zero_q, res_zero_d;

  logic         w_adv, e_adv, accept;
  logic [W-1:0] rf_rd1, rf_rd2;
  logic [W-1:0] opnd_a, opnd_b;

  regfile_8x16 #(
    .REGS (REGS),
    .W    (W)
  ) u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra1     (in_rs1),
    .ra2     (in_rs2),
    .rd1     (rf_rd1),
    .rd2     (rf_rd2),
    .pw_en   (e_adv),
    .pw_addr (e_rd_q),
    .pw_data (alu_out),
    .xw_en   (ld_en),
    .xw_addr (ld_addr),
    .xw_data (ld_data)
  );

  always_comb begin
    w_adv    = !res_valid_q || res_ready;
    e_adv    = e_valid_q && w_adv;
    in_ready = !e_valid_q || w_adv;
    accept   = in_valid && in_ready;

    // The instruction leaving E writes back on this same edge, so forward its result.
    opnd_a = rf_rd1;
    opnd_b = rf_rd2;
    if (e_adv && (e_rd_q == in_rs1) && (in_rs1 != '0)) opnd_a = alu_out;
    if (e_adv && (e_rd_q == in_rs2) && (in_rs2 != '0)) opnd_b = alu_out;
  end

  // Stage E: operands stay frozen unless a new instruction is accepted.
  always_comb begin
    e_valid_d = e_valid_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    e_rd_d    = e_rd_q;
    if (accept) begin
      e_valid_d = 1'b1;
      alu_a_d   = opnd_a;
      alu_b_d   = opnd_b;
      alu_op_d  = alu_op_e'(in_op);
      e_rd_d    = in_rd;
    end else if (e_adv) begin
      e_valid_d = 1'b0;
    end
  end

  // Stage W: result capture.
  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_rd_d    = res_rd_q;
    res_zero_d  = res_zero_q;
    if (e_adv) begin
      res_valid_d = 1'b1;
      res_data_d  = alu_out;
      res_rd_d    = e_rd_q;
      res_zero_d  = alu_zerof;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e_valid_q   <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= OP_ADD;
      e_rd_q      <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_rd_q    <= '0;
      res_zero_q  <= 1'b0;
    end else begin
      e_valid_q   <= e_valid_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      e_rd_q      <= e_rd_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_rd_q    <= res_rd_d;
      res_zero_q  <= res_zero_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_rd    = res_rd_q;
  assign res_zero  = res_zero_q;

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Scoreboard bench for alu_exec_pipe with a behavioural ALU attached and an
// in-order architectural register model.
module tb_alu_exec_pipe;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [2:0]  in_op = '0, in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic        ld_en = 1'b0;
  logic [2:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [2:0]  alu_op;
  logic        alu_zerof;
  logic        res_valid, res_ready = 1'b1, res_zero;
  logic [15:0] res_data;
  logic [2:0]  res_rd;

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_f(logic [2:0] op, logic [15:0] a, logic [15:0] b);
    case (op)
      OP_ADD:   return a + b;
      OP_SUB:   return a - b;
      OP_SHL:   return a << b[3:0];
      OP_SHR:   return a >> b[3:0];
      OP_SRA:   return 16'($signed(a) >>> b[3:0]);
      OP_NAND:  return ~(a & b);
      OP_OR:    return a | b;
      default:  return a + (b << 1);
    endcase
  endfunction

  assign alu_out   = alu_f(alu_op, alu_a, alu_b);
  assign alu_zerof = (alu_out == 16'h0000);

  alu_exec_pipe #(.REGS(8), .W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_zerof(alu_zerof),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_rd(res_rd), .res_zero(res_zero)
  );

  typedef struct {
    logic [15:0] data;
    logic [2:0]  rd;
    logic        z;
    int          cyc;
  } rec_t;

  rec_t        exp_q[$];
  rec_t        got_q[$];
  logic [15:0] mregs [8];
  int          errors = 0, checks = 0, cyc = 0;
  bit          chk_lat = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus side: every accepted instruction is executed on the model in order.
  always @(negedge clk) begin
    rec_t e;
    if (rst_n && in_valid && in_ready) begin
      e.data = alu_f(in_op, mregs[in_rs1], mregs[in_rs2]);
      e.rd   = in_rd;
      e.z    = (e.data == 16'h0000);
      e.cyc  = cyc;
      exp_q.push_back(e);
      if (in_rd != 3'd0) mregs[in_rd] = e.data;
    end
  end

  // Monitor: each result transfer pops one expectation.
  always @(negedge clk) begin
    rec_t e, g;
    if (rst_n && res_valid && res_ready) begin
      g.data = res_data; g.rd = res_rd; g.z = res_zero; g.cyc = cyc;
      got_q.push_back(g);
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("res_data", res_data, e.data);
        chk("res_rd", res_rd, e.rd);
        chk("res_zero", res_zero, e.z);
        if (chk_lat) chk("latency", cyc - e.cyc, 32'd2);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mregs[i] = 16'h0000;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic load(input logic [2:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
    if (a != 3'd0) mregs[a] = d;
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
    bit acc;
    int n = 0;
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_valid = 1'b1;
    do begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0; res_ready = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin tick(); n++; end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 32'd0);
    tick(); tick();
  endtask

  task automatic take(output rec_t g);
    if (got_q.size() == 0) begin
      chk("missing_result", 32'd0, 32'd1);
      g.data = 'x; g.rd = 'x; g.z = 1'bx; g.cyc = 0;
    end else begin
      g = got_q.pop_front();
    end
  endtask

  task automatic check_reset_outputs(string tag);
    @(negedge clk);
    chk({tag, "_res_valid"}, res_valid, 32'd0);
    chk({tag, "_alu_a"}, alu_a, 32'd0);
    chk({tag, "_alu_b"}, alu_b, 32'd0);
    chk({tag, "_alu_op"}, alu_op, 32'd0);
    chk({tag, "_res_data"}, res_data, 32'd0);
    chk({tag, "_res_rd"}, res_rd, 32'd0);
    chk({tag, "_res_zero"}, res_zero, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rec_t g;
    logic [15:0] sa, sb;
    logic [2:0]  sop;

    // Reset
    model_reset();
    rst_n = 1'b0;
    tick(); tick();
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 32'd1);
    @(posedge clk); #1;

    // Load and ADD, then read r3 back through an OR with r0
    chk_lat = 1'b1;
    load(3'd1, 16'h0003);
    load(3'd2, 16'h0005);
    issue(OP_ADD, 3'd3, 3'd1, 3'd2);
    drain();
    take(g);
    chk("add_data", g.data, 32'h0008);
    chk("add_rd", g.rd, 32'd3);
    chk("add_zero", g.z, 32'd0);
    issue(OP_OR, 3'd7, 3'd3, 3'd0);
    drain();
    take(g);
    chk("r3_value", g.data, 32'h0008);

    // Bypass chain; stale r4 would give 0x00F3
    load(3'd4, 16'h00F0);
    issue(OP_SUB, 3'd4, 3'd3, 3'd3);
    issue(OP_OR, 3'd5, 3'd4, 3'd1);
    drain();
    take(g);
    chk("sub_data", g.data, 32'h0000);
    chk("sub_zero", g.z, 32'd1);
    take(g);
    chk("bypass_data", g.data, 32'h0003);

    // Backpressure: two accepts fill E and W, third waits with frozen ALU inputs
    chk_lat = 1'b0;
    got_q.delete();
    res_ready = 1'b0;
    issue(OP_ADD, 3'd1, 3'd1, 3'd2);
    issue(OP_SHL, 3'd2, 3'd1, 3'd1);
    in_op = OP_NAND; in_rd = 3'd6; in_rs1 = 3'd2; in_rs2 = 3'd1; in_valid = 1'b1;
    @(negedge clk);
    chk("bp_in_ready", in_ready, 32'd0);
    sa = alu_a; sb = alu_b; sop = alu_op;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_stable", {13'd0, alu_op, alu_a != sa, alu_b != sb, in_ready},
          {13'd0, sop, 3'b000});
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    issue(OP_NAND, 3'd6, 3'd2, 3'd1);
    drain();
    chk("bp_count", got_q.size(), 32'd3);

    // r0 write discarded, then pipeline write beats a same-edge external load
    chk_lat = 1'b1;
    load(3'd1, 16'h0003);
    load(3'd2, 16'h0005);
    got_q.delete();
    issue(OP_ADD, 3'd0, 3'd1, 3'd2);
    issue(OP_OR, 3'd7, 3'd0, 3'd0);
    drain();
    take(g);
    chk("r0_write_rd", g.rd, 32'd0);
    take(g);
    chk("r0_reads_zero", g.data, 32'h0000);
    issue(OP_ADD, 3'd6, 3'd1, 3'd2);
    ld_en = 1'b1; ld_addr = 3'd6; ld_data = 16'hBEEF;
    tick();
    ld_en = 1'b0;
    drain();
    issue(OP_OR, 3'd7, 3'd6, 3'd0);
    drain();
    got_q.delete();
    issue(OP_OR, 3'd7, 3'd6, 3'd0);
    drain();
    take(g);
    chk("same_index_pipe_wins", g.data, 32'h0008);

    // Reset with E and W both occupied
    chk_lat = 1'b0;
    res_ready = 1'b0;
    issue(OP_ADD, 3'd1, 3'd1, 3'd2);
    issue(OP_ADD, 3'd2, 3'd1, 3'd2);
    rst_n = 1'b0;
    tick();
    check_reset_outputs("midreset");
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    res_ready = 1'b1;
    issue(OP_OR, 3'd7, 3'd1, 3'd2);
    drain();
    take(g);
    chk("midreset_regs_cleared", g.data, 32'h0000);

    // Shift ops
    chk_lat = 1'b1;
    load(3'd1, 16'h8000);
    load(3'd2, 16'h0001);
    issue(OP_SRA, 3'd3, 3'd1, 3'd2);
    drain();
    take(g);
    chk("sra_data", g.data, 32'h0000C000);
    load(3'd1, 16'h0001);
    load(3'd2, 16'h0002);
    issue(OP_SHADD, 3'd4, 3'd1, 3'd2);
    drain();
    take(g);
    chk("shadd_data", g.data, 32'h0005);

    // Randomized traffic with random backpressure
    chk_lat = 1'b0;
    for (int b = 0; b < 20; b++) begin
      load(3'($urandom_range(1, 7)), 16'($urandom));
      load(3'($urandom_range(1, 7)), 16'($urandom));
      for (int c = 0; c < 30; c++) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_op     = 3'($urandom);
        in_rd     = 3'($urandom);
        in_rs1    = 3'($urandom);
        in_rs2    = 3'($urandom);
        res_ready = ($urandom_range(0, 9) < 7);
        tick();
      end
      drain();
    end

    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
